// File: rtl/dm_arbiter.sv
// Two-master arbiter/sequencer in front of the 1024x32 synchronous data memory.
// Partial-byte stores are turned into a read-modify-write of the full word.
module dm_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [9:0]  m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [9:0]  m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RD, RD_RESP, WR, RMW_RD, RMW_MRG} state_t;

    state_t      state, state_next;
    logic        op_we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        g;
    logic        last_g;

    logic        grant_valid;
    logic        grant_id;
    logic        sel_we;
    logic [3:0]  sel_be;
    logic [9:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic        ack;

    // Round-robin favours the master that was not served last; fixed priority favours master 0.
    always_comb begin
        grant_valid = m0_req | m1_req;
        grant_id    = 1'b0;
        if (m0_req && m1_req) begin
            grant_id = FIXED_PRIO ? 1'b0 : ~last_g;
        end else if (m1_req) begin
            grant_id = 1'b1;
        end
        sel_we    = grant_id ? m1_we    : m0_we;
        sel_be    = grant_id ? m1_be    : m0_be;
        sel_addr  = grant_id ? m1_addr  : m0_addr;
        sel_wdata = grant_id ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    if (!sel_we) begin
                        state_next = RD;
                    end else if (sel_be == 4'hF || sel_be == 4'h0) begin
                        state_next = WR;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            RD:      state_next = RD_RESP;
            RD_RESP: state_next = IDLE;
            WR:      state_next = IDLE;
            RMW_RD:  state_next = RMW_MRG;
            RMW_MRG: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_g <= 1'b1;
            op_we  <= 1'b0;
            be     <= 4'h0;
            addr   <= 10'h0;
            wdata  <= 32'h0;
            g      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                op_we  <= sel_we;
                be     <= sel_be;
                addr   <= sel_addr;
                wdata  <= sel_wdata;
                g      <= grant_id;
                last_g <= grant_id;
            end
        end
    end

    // Memory strobes and acks come only from state and latched fields, never from live requests.
    always_comb begin
        mem_addr = addr;
        mem_din  = 32'h0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        ack      = 1'b0;
        case (state)
            RD, RMW_RD: mem_re = 1'b1;
            RD_RESP:    ack = 1'b1;
            WR: begin
                ack = 1'b1;
                if (be == 4'hF) begin
                    mem_we  = 1'b1;
                    mem_din = wdata;
                end
            end
            RMW_MRG: begin
                ack    = 1'b1;
                mem_we = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    mem_din[8*i +: 8] = be[i] ? wdata[8*i +: 8] : mem_dout[8*i +: 8];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        m0_ack   = ack & ~g;
        m1_ack   = ack & g;
        m0_rdata = (state == RD_RESP && !g && !op_we) ? mem_dout : 32'h0;
        m1_rdata = (state == RD_RESP &&  g && !op_we) ? mem_dout : 32'h0;
        busy     = (state != IDLE);
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and sequencer in front of the 4 KiB data memory (1024 x 32, synchronous single-port: one-cycle registered read, word-only write).
- Shares the memory between master 0 (CPU load/store unit) and master 1 (DMA/debug loader).
- Adds byte-enable stores by sequencing a read-modify-write.
- Drives the memory's addr/din/we/re directly and consumes its dout.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 always wins a tie.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  asynchronous, active-high reset.
m0_req  input  1  master 0 request; held until m0_ack.
m0_we  input  1  1 = store, 0 = load.
m0_be  input  4  byte enables for stores; be[0] = bits 7:0.
m0_addr  input  10  word address [11:2].
m0_wdata  input  32  store data.
m0_ack  output  1  one-cycle completion pulse.
m0_rdata  output  32  load data; valid only while m0_ack is high for a load.
m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0.
mem_addr  output  10  to memory addr[11:2].
mem_din  output  32  to memory din.
mem_we  output  1  to memory we.
mem_re  output  1  to memory re.
mem_dout  input  32  from memory dout.
busy  output  1  high in any state other than IDLE.

Behaviour:
- State register in {IDLE, RD, RD_RESP, WR, RMW_RD, RMW_MRG}.
- Latched request registers: op, be, addr, wdata, grant id (g).
- Round-robin pointer last_g.
- All mem_* outputs and acks decode combinationally from state plus latched registers. No combinational path from m*_req to mem_* or acks.
- Reset (async, immediate):
  - state = IDLE, last_g = 1 (master 0 wins the first tie), latched registers = 0.
  - mem_we = mem_re = 0, mem_addr = 0, mem_din = 0, acks = 0, busy = 0.
- IDLE arbitration at posedge:
  - Only one req high: grant it.
  - Both high: FIXED_PRIO=1 grants master 0; otherwise grant the master != last_g.
  - On grant: latch that master's fields, set last_g = g.
  - Next state: load -> RD; store with be=1111 or be=0000 -> WR; any other be -> RMW_RD.
  - No req: stay IDLE.
- RD: mem_re=1, mem_addr=latched addr. -> RD_RESP.
- RD_RESP:
  - Memory output now valid. m{g}_ack=1, m{g}_rdata=mem_dout. -> IDLE.
  - Load latency: 2 cycles from the accepting edge to the ack cycle.
- WR:
  - be=1111: mem_we=1, mem_din=wdata.
  - be=0000: mem_we=0, no memory access.
  - m{g}_ack=1 in the same cycle. Write commits at the edge ending WR. -> IDLE.
- RMW_RD: mem_re=1. -> RMW_MRG.
- RMW_MRG:
  - mem_we=1, mem_re=0.
  - mem_din byte i = be[i] ? wdata byte i : mem_dout byte i.
  - m{g}_ack=1. -> IDLE.
  - Partial-store latency: 2 cycles.
- m*_rdata when not acking a load = 0. The non-granted master's ack is always 0.
- Handshake rules:
  - Master holds req and fields stable until it samples ack.
  - req still high in the edge after ack = new request, re-arbitrated in IDLE.
  - Changing fields while waiting is unsupported; latched values are used.
- One transaction at a time. A master requesting while the other is served waits in IDLE arbitration. Round-robin guarantees at most one intervening transaction.
- Reset mid-operation:
  - In RMW_RD or RD: no write occurs, no ack issued.
  - In WR or RMW_MRG before the edge: the write is dropped.
  - Both masters re-request after reset.
- Address wrap: none; addresses outside [11:2] are not representable.

Test Plan:
- Full store m0 addr=0x010 wdata=0xDEADBEEF be=1111, then m0 load 0x010 -> ack 1 cycle after accept for the store; load ack 2 cycles after accept with rdata=0xDEADBEEF.
- Preload 0x020=0x11223344; m1 store be=0101 wdata=0xAABBCCDD -> RMW_RD then RMW_MRG; word becomes 0x11BB33DD, one mem_we pulse.
- m0 and m1 both request continuously, FIXED_PRIO=0, from reset -> grants alternate m0, m1, m0, m1; each ack one cycle and only to the granted master.
- Same as above with FIXED_PRIO=1 -> m0 granted every time while its req stays high; m1 served only once m0 drops req.
- Store be=0000 to 0x030 holding 0x55 -> ack after 1 cycle, mem_we never asserted, word still 0x55.
- Assert rst during RMW_RD of a partial store -> state IDLE immediately, no ack, target word unchanged, busy=0.
